// File: rtl/riscv_core_pkg.sv
// Shared definitions for the writeback arbiter slice.
//   - Requester indices (bit positions in the per-requester wb_* vectors).
//   - NUM_REQ: number of writeback requesters.
//   - REG_ADDR_W: architectural register index width.
//   - rr_ptr_e: round-robin pointer encoding, named after the
//     requester that currently has highest priority.
package riscv_core_pkg;

  localparam int NUM_REQ    = 3;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  localparam int WB_ALU = 0;
  localparam int WB_LSU = 1;
  localparam int WB_MDU = 2;

  typedef enum logic [1:0] {
    RR_ALU = 2'd0,
    RR_LSU = 2'd1,
    RR_MDU = 2'd2
  } rr_ptr_e;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bus between the three requesters and the arbiter.
//   wb_valid_pi [NUM_REQ]       : per-requester valid (0 ALU, 1 LSU, 2 MDU/CSR)
//   wb_rd_pi    [NUM_REQ*5]     : packed {rd2, rd1, rd0}
//   wb_data_pi  [NUM_REQ*XLEN]  : packed {data2, data1, data0}
//   wb_ready_po [NUM_REQ]       : one-hot grant from the arbiter
// Handshake: a transfer completes in a cycle where valid[k] and ready[k]
// are both high at the rising edge. Once valid[k] is raised, rd and data
// of requester k stay stable and valid stays high until that transfer.
interface regfile_wb_arbiter_if
  import riscv_core_pkg::*;
#(
  parameter int XLEN = 32
);
  logic [NUM_REQ-1:0]            wb_valid_pi;
  logic [NUM_REQ*REG_ADDR_W-1:0] wb_rd_pi;
  logic [NUM_REQ*XLEN-1:0]       wb_data_pi;
  logic [NUM_REQ-1:0]            wb_ready_po;

  // Requester side.
  modport master (
    output wb_valid_pi,
    output wb_rd_pi,
    output wb_data_pi,
    input  wb_ready_po
  );

  // Arbiter side.
  modport slave (
    input  wb_valid_pi,
    input  wb_rd_pi,
    input  wb_data_pi,
    output wb_ready_po
  );
endinterface

// File: rtl/rr_arbiter3.sv
// Three-way round-robin arbiter: pointer register plus combinational
// one-hot grant. No data path.
//   clk, reset     : clock, asynchronous active-low reset
//   valid_pi [3]   : request vector
//   grant_po [3]   : one-hot grant (0 when nothing is valid)
//   rr_ptr_po      : current highest-priority requester (debug/state view)
// A grant is a completed transfer (valid is a precondition of grant), so
// the pointer advances past the winner on every cycle with a grant.
module rr_arbiter3
  import riscv_core_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] valid_pi,
  output logic [2:0] grant_po,
  output rr_ptr_e    rr_ptr_po
);

  rr_ptr_e rr_ptr_q;

  // Search order rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3).
  always_comb begin
    grant_po = 3'b000;
    case (rr_ptr_q)
      RR_LSU: begin
        if      (valid_pi[1]) grant_po = 3'b010;
        else if (valid_pi[2]) grant_po = 3'b100;
        else if (valid_pi[0]) grant_po = 3'b001;
      end
      RR_MDU: begin
        if      (valid_pi[2]) grant_po = 3'b100;
        else if (valid_pi[0]) grant_po = 3'b001;
        else if (valid_pi[1]) grant_po = 3'b010;
      end
      default: begin
        if      (valid_pi[0]) grant_po = 3'b001;
        else if (valid_pi[1]) grant_po = 3'b010;
        else if (valid_pi[2]) grant_po = 3'b100;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q <= RR_ALU;
    end else begin
      case (grant_po)
        3'b001:  rr_ptr_q <= RR_LSU;
        3'b010:  rr_ptr_q <= RR_MDU;
        3'b100:  rr_ptr_q <= RR_ALU;
        default: rr_ptr_q <= rr_ptr_q;
      endcase
    end
  end

  assign rr_ptr_po = rr_ptr_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file's single write port among ALU, LSU and
// MULDIV/CSR writeback requesters (round-robin), and tracks pending
// long-latency destinations for decode-stage RAW/WAW hazard detection.
//   clk, reset                : clock, asynchronous active-low reset
//   wb (slave modport)        : writeback valid/rd/data in, one-hot ready out
//   issue_valid_pi/_rd_pi     : decode issues a long-latency op writing rd
//   issue_ready_po            : low when issue_rd_pi is already pending
//   rs1_pi/rs2_pi             : decode source registers
//   rs1_busy_po/rs2_busy_po   : source has a pending write not yet on the port
//   rf_we_po/rf_rd_po/rf_wdata_po : drive reg_file write port
//   dbg_rr_ptr_po             : round-robin pointer
//   dbg_pending_po            : pending-write scoreboard
module regfile_wb_arbiter
  import riscv_core_pkg::*;
#(
  parameter int XLEN = 32
)(
  input  logic                  clk,
  input  logic                  reset,
  regfile_wb_arbiter_if.slave   wb,
  input  logic                  issue_valid_pi,
  input  logic [REG_ADDR_W-1:0] issue_rd_pi,
  output logic                  issue_ready_po,
  input  logic [REG_ADDR_W-1:0] rs1_pi,
  input  logic [REG_ADDR_W-1:0] rs2_pi,
  output logic                  rs1_busy_po,
  output logic                  rs2_busy_po,
  output logic                  rf_we_po,
  output logic [REG_ADDR_W-1:0] rf_rd_po,
  output logic [XLEN-1:0]       rf_wdata_po,
  output logic [1:0]            dbg_rr_ptr_po,
  output logic [NUM_REGS-1:0]   dbg_pending_po
);

  logic [NUM_REQ-1:0]    grant;
  rr_ptr_e               rr_ptr;
  logic [REG_ADDR_W-1:0] winner_rd;
  logic [XLEN-1:0]       winner_data;
  logic                  clr_en;
  logic                  set_en;
  logic [NUM_REGS-1:0]   pending_q;
  logic [NUM_REGS-1:0]   pending_d;

  rr_arbiter3 u_rr (
    .clk       (clk),
    .reset     (reset),
    .valid_pi  (wb.wb_valid_pi),
    .grant_po  (grant),
    .rr_ptr_po (rr_ptr)
  );

  assign wb.wb_ready_po = grant;

  // Winner mux; grant is one-hot so at most one branch fires.
  always_comb begin
    winner_rd   = '0;
    winner_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) begin
        winner_rd   = wb.wb_rd_pi[k*REG_ADDR_W +: REG_ADDR_W];
        winner_data = wb.wb_data_pi[k*XLEN +: XLEN];
      end
    end
  end

  // x0 writes are still granted and consumed, just never written.
  assign rf_we_po    = (|grant) & (winner_rd != '0);
  assign rf_rd_po    = winner_rd;
  assign rf_wdata_po = winner_data;

  // Only long-latency producers (LSU, MDU) retire scoreboard entries.
  assign clr_en = grant[WB_LSU] | grant[WB_MDU];

  // A destination retiring this cycle frees it for a new producer and is
  // not busy, since reg_file forwards the write data combinationally.
  assign issue_ready_po = ~pending_q[issue_rd_pi] | (clr_en & (winner_rd == issue_rd_pi));
  assign rs1_busy_po    = pending_q[rs1_pi] & ~(clr_en & (winner_rd == rs1_pi));
  assign rs2_busy_po    = pending_q[rs2_pi] & ~(clr_en & (winner_rd == rs2_pi));

  assign set_en = issue_valid_pi & issue_ready_po & (issue_rd_pi != '0);

  // Set is applied after clear so a same-cycle retire/issue leaves it set.
  always_comb begin
    pending_d = pending_q;
    if (clr_en) pending_d[winner_rd] = 1'b0;
    if (set_en) pending_d[issue_rd_pi] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign dbg_rr_ptr_po  = rr_ptr;
  assign dbg_pending_po = pending_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: inputs change 1 ns after a rising
// edge, outputs are checked before the next rising edge.
module tb_regfile_wb_arbiter;
  import riscv_core_pkg::*;

  localparam int XLEN = 32;

  logic                  clk;
  logic                  reset;
  logic                  issue_valid;
  logic [REG_ADDR_W-1:0] issue_rd;
  logic                  issue_ready;
  logic [REG_ADDR_W-1:0] rs1;
  logic [REG_ADDR_W-1:0] rs2;
  logic                  rs1_busy;
  logic                  rs2_busy;
  logic                  rf_we;
  logic [REG_ADDR_W-1:0] rf_rd;
  logic [XLEN-1:0]       rf_wdata;
  logic [1:0]            dbg_ptr;
  logic [NUM_REGS-1:0]   dbg_pending;

  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter_if #(.XLEN(XLEN)) wb_if ();

  regfile_wb_arbiter #(.XLEN(XLEN)) dut (
    .clk            (clk),
    .reset          (reset),
    .wb             (wb_if),
    .issue_valid_pi (issue_valid),
    .issue_rd_pi    (issue_rd),
    .issue_ready_po (issue_ready),
    .rs1_pi         (rs1),
    .rs2_pi         (rs2),
    .rs1_busy_po    (rs1_busy),
    .rs2_busy_po    (rs2_busy),
    .rf_we_po       (rf_we),
    .rf_rd_po       (rf_rd),
    .rf_wdata_po    (rf_wdata),
    .dbg_rr_ptr_po  (dbg_ptr),
    .dbg_pending_po (dbg_pending)
  );

  // Clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Requester protocol: a valid not yet granted must stay high.
  logic [2:0] hold_q = 3'b000;
  always @(posedge clk) begin
    if (reset) begin
      assert ((hold_q & ~wb_if.wb_valid_pi) == 3'b000)
      else begin
        errors++;
        $error("FAIL protocol: valid dropped before ready, held=%b valid=%b", hold_q, wb_if.wb_valid_pi);
      end
      hold_q = wb_if.wb_valid_pi & ~wb_if.wb_ready_po;
    end else begin
      hold_q = 3'b000;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic v, input logic [4:0] rd, input logic [31:0] d);
    wb_if.wb_valid_pi[k]                 = v;
    wb_if.wb_rd_pi[k*REG_ADDR_W +: REG_ADDR_W] = rd;
    wb_if.wb_data_pi[k*XLEN +: XLEN]     = d;
  endtask

  logic [2:0] fair_exp [6];

  initial begin
    fair_exp[0] = 3'b001; fair_exp[1] = 3'b010; fair_exp[2] = 3'b100;
    fair_exp[3] = 3'b001; fair_exp[4] = 3'b010; fair_exp[5] = 3'b100;

    reset = 1'b0;
    wb_if.wb_valid_pi = '0;
    wb_if.wb_rd_pi    = '0;
    wb_if.wb_data_pi  = '0;
    issue_valid = 1'b0;
    issue_rd    = '0;
    rs1         = '0;
    rs2         = '0;

    // Reset state
    step();
    step();
    check("reset_ptr", 64'(dbg_ptr), 64'd0);
    check("reset_pending", 64'(dbg_pending), 64'd0);
    check("reset_ready", 64'(wb_if.wb_ready_po), 64'd0);
    check("reset_we", 64'(rf_we), 64'd0);
    check("reset_rf_rd", 64'(rf_rd), 64'd0);
    check("reset_wdata", 64'(rf_wdata), 64'd0);
    check("reset_issue_ready", 64'(issue_ready), 64'd1);
    reset = 1'b1;
    step();

    // Single ALU request
    set_req(WB_ALU, 1'b1, 5'd5, 32'hDEADBEEF);
    #1;
    check("single_ready", 64'(wb_if.wb_ready_po), 64'b001);
    check("single_we", 64'(rf_we), 64'd1);
    check("single_rd", 64'(rf_rd), 64'd5);
    check("single_wdata", 64'(rf_wdata), 64'hDEADBEEF);
    step();
    set_req(WB_ALU, 1'b0, 5'd0, 32'h0);
    #1;
    check("single_ptr", 64'(dbg_ptr), 64'd1);
    check("idle_wdata", 64'(rf_wdata), 64'd0);
    check("alu_no_pending", 64'(dbg_pending), 64'd0);

    // Fairness from reset
    reset = 1'b0;
    #2;
    check("rst_pulse_ptr", 64'(dbg_ptr), 64'd0);
    reset = 1'b1;
    step();
    set_req(WB_ALU, 1'b1, 5'd1, 32'hA0A0_0001);
    set_req(WB_LSU, 1'b1, 5'd2, 32'hB0B0_0002);
    set_req(WB_MDU, 1'b1, 5'd3, 32'hC0C0_0003);
    #1;
    for (int c = 0; c < 6; c++) begin
      check($sformatf("fair_grant%0d", c), 64'(wb_if.wb_ready_po), 64'(fair_exp[c]));
      step();
    end
    check("drain_grant0", 64'(wb_if.wb_ready_po), 64'b001);
    check("drain_rd0", 64'(rf_rd), 64'd1);
    step();
    set_req(WB_ALU, 1'b0, 5'd0, 32'h0);
    #1;
    check("drain_grant1", 64'(wb_if.wb_ready_po), 64'b010);
    check("drain_wdata1", 64'(rf_wdata), 64'hB0B0_0002);
    step();
    set_req(WB_LSU, 1'b0, 5'd0, 32'h0);
    #1;
    check("drain_grant2", 64'(wb_if.wb_ready_po), 64'b100);
    check("drain_rd2", 64'(rf_rd), 64'd3);
    step();
    set_req(WB_MDU, 1'b0, 5'd0, 32'h0);
    #1;
    check("after_fair_ptr", 64'(dbg_ptr), 64'd0);

    // x0 write from LSU
    set_req(WB_LSU, 1'b1, 5'd0, 32'h0000_1234);
    #1;
    check("x0_ready", 64'(wb_if.wb_ready_po), 64'b010);
    check("x0_we", 64'(rf_we), 64'd0);
    check("x0_wdata", 64'(rf_wdata), 64'h1234);
    step();
    set_req(WB_LSU, 1'b0, 5'd0, 32'h0);
    #1;
    check("x0_pending", 64'(dbg_pending), 64'd0);
    check("x0_ptr", 64'(dbg_ptr), 64'd2);

    // Scoreboard flow on rd=7
    issue_valid = 1'b1;
    issue_rd    = 5'd7;
    #1;
    check("issue7_ready", 64'(issue_ready), 64'd1);
    step();
    issue_valid = 1'b0;
    rs1 = 5'd7;
    rs2 = 5'd8;
    #1;
    check("rs1_busy7", 64'(rs1_busy), 64'd1);
    check("rs2_notbusy8", 64'(rs2_busy), 64'd0);
    check("waw_stall7", 64'(issue_ready), 64'd0);
    check("pending7", 64'(dbg_pending), 64'h80);
    set_req(WB_LSU, 1'b1, 5'd7, 32'h7777_0007);
    #1;
    check("lsu7_grant", 64'(wb_if.wb_ready_po), 64'b010);
    check("lsu7_busy_same_cycle", 64'(rs1_busy), 64'd0);
    check("lsu7_issue_ready", 64'(issue_ready), 64'd1);
    check("lsu7_we", 64'(rf_we), 64'd1);
    step();
    set_req(WB_LSU, 1'b0, 5'd0, 32'h0);
    #1;
    check("pending7_cleared", 64'(dbg_pending), 64'd0);
    check("rs1_free7", 64'(rs1_busy), 64'd0);

    // Simultaneous clear and set on rd=9
    issue_valid = 1'b1;
    issue_rd    = 5'd9;
    step();
    issue_valid = 1'b0;
    #1;
    check("pending9", 64'(dbg_pending), 64'h200);
    set_req(WB_MDU, 1'b1, 5'd9, 32'h9999_0009);
    issue_valid = 1'b1;
    issue_rd    = 5'd9;
    rs2         = 5'd9;
    #1;
    check("sim_grant", 64'(wb_if.wb_ready_po), 64'b100);
    check("sim_issue_ready", 64'(issue_ready), 64'd1);
    check("sim_rs2_busy", 64'(rs2_busy), 64'd0);
    step();
    set_req(WB_MDU, 1'b0, 5'd0, 32'h0);
    issue_valid = 1'b0;
    #1;
    check("sim_pending9_kept", 64'(dbg_pending), 64'h200);
    check("sim_ptr", 64'(dbg_ptr), 64'd0);

    // Reset mid-operation: set pending 3 and 12, move pointer to 2
    set_req(WB_LSU, 1'b1, 5'd0, 32'h0);
    issue_valid = 1'b1;
    issue_rd    = 5'd3;
    step();
    set_req(WB_LSU, 1'b0, 5'd0, 32'h0);
    issue_rd = 5'd12;
    step();
    issue_valid = 1'b0;
    #1;
    check("pre_rst_pending", 64'(dbg_pending), 64'h1208);
    check("pre_rst_ptr", 64'(dbg_ptr), 64'd2);
    set_req(WB_ALU, 1'b1, 5'd4, 32'h4444_0004);
    set_req(WB_LSU, 1'b1, 5'd5, 32'h5555_0005);
    set_req(WB_MDU, 1'b1, 5'd6, 32'h6666_0006);
    #1;
    check("pre_rst_grant", 64'(wb_if.wb_ready_po), 64'b100);
    #1;
    reset = 1'b0;
    #1;
    check("rst_async_pending", 64'(dbg_pending), 64'd0);
    check("rst_async_ptr", 64'(dbg_ptr), 64'd0);
    check("rst_grant", 64'(wb_if.wb_ready_po), 64'b001);
    step();
    reset = 1'b1;
    #1;
    check("post_rst_grant", 64'(wb_if.wb_ready_po), 64'b001);
    step();
    set_req(WB_ALU, 1'b0, 5'd0, 32'h0);
    #1;
    check("post_rst_grant1", 64'(wb_if.wb_ready_po), 64'b010);
    step();
    set_req(WB_LSU, 1'b0, 5'd0, 32'h0);
    #1;
    check("post_rst_grant2", 64'(wb_if.wb_ready_po), 64'b100);
    step();
    set_req(WB_MDU, 1'b0, 5'd0, 32'h0);
    #1;
    check("final_idle", 64'(wb_if.wb_ready_po), 64'd0);
    check("final_pending", 64'(dbg_pending), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog
  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: observed timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the register file's single write port among three writeback requesters (ALU, load/store unit, multiply/divide-CSR unit) with round-robin arbitration and valid/ready handshakes. It also keeps a 32-entry pending-write scoreboard so the decode stage can detect RAW/WAW hazards on long-latency destinations. It sits between the execute/memory stages and `reg_file` and drives that module's `we_pi`/`destReg_pi`/`writeData_pi` directly.

## Interface
- `NUM_REQ`, 3: number of writeback requesters; the RTL supports exactly 3.
- `XLEN`, 32: data width.
- Reset is asynchronous and active-low.
- `clk` input 1: single clock, all state on rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `wb_valid_pi` input 3: per-requester writeback valid. Bit 0 = ALU, 1 = LSU, 2 = MULDIV/CSR.
- `wb_rd_pi` input 3x5: per-requester destination register, packed `{rd2,rd1,rd0}`.
- `wb_data_pi` input 3xXLEN: per-requester write data, packed.
- `wb_ready_po` output 3: one-hot grant; the transfer completes when valid and ready are both high.
- `issue_valid_pi` input 1: decode issues a long-latency op (LSU load or MULDIV) that will write `issue_rd_pi`.
- `issue_rd_pi` input 5: destination of the issued op.
- `issue_ready_po` output 1: low when `issue_rd_pi` is already pending (WAW stall).
- `rs1_pi`, `rs2_pi` input 5 each: source registers of the instruction in decode.
- `rs1_busy_po`, `rs2_busy_po` output 1 each: the source has a pending write not yet on the port.
- `rf_we_po` output 1: to `reg_file.we_pi`.
- `rf_rd_po` output 5: to `reg_file.destReg_pi`.
- `rf_wdata_po` output XLEN: to `reg_file.writeData_pi`.

## Operation
- **Arbitration**
  - Round-robin with a 2-bit pointer `rr_ptr` (values 0..2) naming the highest-priority requester.
  - Search order: `rr_ptr`, `rr_ptr+1`, `rr_ptr+2` (mod 3).
  - The first valid requester in that order gets `wb_ready_po` = one-hot; all others get 0.
  - After a completed transfer by requester k, `rr_ptr <= (k+1) mod 3`. With no transfer, `rr_ptr` holds.
- **Write port**
  - `rf_we_po = |wb_ready_po & (winner_rd != 0)`.
  - `rf_rd_po` and `rf_wdata_po` are muxed from the winner; they are 0 when there is no winner.
  - A write to x0 is still granted and consumed, but `rf_we_po` stays 0.
- **Requester rule**
  - A requester holds valid, rd and data stable until ready.
  - Deasserting valid before ready is a protocol violation; the arbiter's behaviour is then undefined (assertion in bench).
- **Scoreboard**: `pending[31:0]`, bit 0 hard-wired 0.
  - Set: `issue_valid_pi & issue_ready_po & issue_rd_pi != 0` sets `pending[issue_rd_pi]`.
  - Clear: a completed transfer from requester 1 or 2 clears `pending[winner_rd]`. ALU writebacks never touch the scoreboard.
  - Same register set and cleared in one cycle: set wins, so the bit stays 1 (a new producer is issued as the old one retires).
  - `issue_ready_po = ~pending[issue_rd_pi] | (clear this cycle of same rd)`.
  - `rsN_busy_po = pending[rsN_pi] & ~(clear this cycle of rsN_pi)`. A register being written this cycle is not busy, because `reg_file` forwards `writeData_pi` combinationally.
  - A clear of a non-pending bit is harmless; no error flag.

## Timing
- Grant, write-port outputs, `issue_ready_po` and `rsN_busy_po` are combinational from the current inputs plus registered state; zero-cycle latency.
- `pending` and `rr_ptr` update on the rising edge following the event.
- Throughput: one writeback per cycle. A continuously valid requester waits at most 2 cycles.
- Reset (asynchronous assert, at any time including mid-transfer): `rr_ptr = 0`, `pending = 0`. Any in-flight long-latency op is forgotten.
- Outputs during reset: `wb_ready_po` and `rf_*` follow combinationally from inputs with `rr_ptr = 0`. Decode is held by the core's reset, so no issue occurs.
- Reset deassertion is synchronised externally.

## Structure
- Shared package `riscv_core_pkg` holds:
  - requester index constants `WB_ALU=0`, `WB_LSU=1`, `WB_MDU=2`;
  - `NUM_REQ`;
  - `REG_ADDR_W=5`.
- One natural sub-module, `rr_arbiter3`: round-robin pointer plus one-hot grant, no data path. The scoreboard and data mux stay inline.

## Test plan
- **Single request**: ALU valid, rd=5, data=0xDEADBEEF → `wb_ready_po=001`, `rf_we_po=1`, `rf_rd_po=5`, `rf_wdata_po=0xDEADBEEF`, `rr_ptr` becomes 1.
- **Fairness**: all three valid for 6 cycles from reset → grants 001, 010, 100, 001, 010, 100.
- **x0 write**: LSU valid, rd=0, data=0x1234 → `wb_ready_po=010`, `rf_we_po=0`; `pending` unchanged.
- **Scoreboard flow**:
  - issue rd=7 → `rs1_pi=7` gives busy=1 next cycle; `issue_rd_pi=7` gives `issue_ready_po=0`.
  - LSU writeback rd=7 → busy=0 in that same cycle; `pending[7]=0` after the edge.
- **Simultaneous events**: same cycle, MDU writeback rd=9 clears while issue rd=9 → `issue_ready_po=1`; `pending[9]=1` after the edge.
- **Reset mid-operation**: `pending[3]`, `pending[12]` set, `rr_ptr=2`; assert reset asynchronously between edges → `pending=0` and `rr_ptr=0` immediately; after release, all-valid gives first grant 001.
